// File: rtl/mem_responder.sv
// mem_responder: line-granular main-memory model for the arbiter's memory port.
// It handles one transaction at a time: either a whole-line read or a whole-line write.
// Read and write latencies are set by parameters.
// Addresses above the stored range are reported on hresp.
module mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hreq,
    input  logic [ADDR_W-1:0]       haddr,
    input  logic                    hwrite,
    input  logic [LINE_BYTES*8-1:0] hwdata,
    output logic                    hready,
    output logic [LINE_BYTES*8-1:0] hrdata,
    output logic                    hresp
);

    localparam int OFS     = $clog2(LINE_BYTES);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LINE_W  = LINE_BYTES * 8;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_PH,
        S_WDATA,
        S_WBUSY,
        S_RBUSY,
        S_RDONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic              hready_q, hready_d;
    logic [LINE_W-1:0] hrdata_q, hrdata_d;
    logic              hresp_q, hresp_d;
    logic              mem_we;
    logic [LINE_W-1:0] mem_q [DEPTH];

    // The line index ignores the byte-offset bits.
    // Any address bit above the index field marks the address as unmapped.
    logic [IDX_W-1:0]  addr_idx;
    logic              addr_err;

    assign addr_idx = haddr[OFS+IDX_W-1:OFS];
    assign addr_err = (haddr >> (OFS + IDX_W)) != '0;

    assign hready = hready_q;
    assign hrdata = hrdata_q;
    assign hresp  = hresp_q;

    // Next-state and output decode for the transaction sequencer.
    always_comb begin
        // NOTE: every signal is first given its hold/idle value, so no path
        // through the case statement leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        hready_d = hready_q;
        hrdata_d = hrdata_q;
        hresp_d  = hresp_q;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE, S_RDONE: begin
                // A request in RDONE is accepted the same way as in IDLE.
                if (hreq) begin
                    state_d  = S_ADDR_PH;
                    hready_d = 1'b0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ADDR_PH: begin
                idx_d = addr_idx;
                err_d = addr_err;
                if (hwrite) begin
                    state_d = S_WDATA;
                end else begin
                    state_d = S_RBUSY;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                end
            end
            S_WDATA: begin
                // A write to an unmapped address is dropped.
                // The error is still reported when the write completes.
                mem_we  = !err_q;
                state_d = S_WBUSY;
                cnt_d   = CNT_W'(WR_LAT - 1);
            end
            S_WBUSY: begin
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    hready_d = 1'b1;
                    hresp_d  = err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RBUSY: begin
                if (cnt_q == '0) begin
                    state_d  = S_RDONE;
                    hready_d = 1'b1;
                    hresp_d  = err_q;
                    hrdata_d = err_q ? '0 : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                hready_d = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // All flops then update together from the values sampled at the edge.
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            hready_q <= 1'b1;
            hrdata_q <= '0;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            hready_q <= hready_d;
            hrdata_q <= hrdata_d;
            hresp_q  <= hresp_d;
        end
    end

    // Line storage: whole-line writes, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately reset here, because reset must
        // leave every line reading 0. That is why it is built from flops
        // rather than from a RAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= hwdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, self-checking bench for mem_responder.
// Read expectations come from a line model and are queued when each read is issued.
// They are compared when hready reports completion.
module tb_mem_responder;

    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 16;
    localparam int DEPTH      = 256;
    localparam int RD_LAT     = 4;
    localparam int WR_LAT     = 2;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WAIT_MAX   = 40;

    typedef struct packed {
        logic              resp;
        logic [LINE_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              hreq;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [LINE_W-1:0] hwdata;
    logic              hready;
    logic [LINE_W-1:0] hrdata;
    logic              hresp;

    int                errors = 0;
    int                checks = 0;
    int                cyc    = 0;
    exp_t              sb [$];
    logic [LINE_W-1:0] model_mem [DEPTH];

    mem_responder #(
        .ADDR_W    (ADDR_W),
        .LINE_BYTES(LINE_BYTES),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .hreq  (hreq),
        .haddr (haddr),
        .hwrite(hwrite),
        .hwdata(hwdata),
        .hready(hready),
        .hrdata(hrdata),
        .hresp (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return a[31:12] == 20'h0;
    endfunction

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'(a[11:4]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for hready, one cycle at a time, up to WAIT_MAX cycles.
    // If the wait runs out, that counts as a failed comparison.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (hready !== 1'b1 && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, LINE_W'(hready), LINE_W'(1));
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data, input string tag);
        int a;
        hreq = 1'b1;
        tick();
        a = cyc;
        check({tag, "_accept"}, LINE_W'(hready), LINE_W'(0));
        hreq   = 1'b0;
        haddr  = addr;
        hwrite = 1'b1;
        tick();
        hwdata = data;
        haddr  = 32'hDEAD_BEEF;
        hwrite = 1'b0;
        tick();
        hwdata = {4{$urandom()}};
        wait_ready(tag);
        check({tag, "_lat"}, LINE_W'(cyc - a), LINE_W'(2 + WR_LAT));
        check({tag, "_resp"}, LINE_W'(hresp), LINE_W'(!is_mapped(addr)));
        if (is_mapped(addr)) model_mem[line_of(addr)] = data;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input string tag);
        int   a;
        exp_t e;
        hreq = 1'b1;
        tick();
        a = cyc;
        check({tag, "_accept"}, LINE_W'(hready), LINE_W'(0));
        hreq   = 1'b0;
        haddr  = addr;
        hwrite = 1'b0;
        sb.push_back({!is_mapped(addr), is_mapped(addr) ? model_mem[line_of(addr)] : LINE_W'(0)});
        tick();
        haddr  = 32'hFFFF_FFF0;
        hwrite = 1'b1;
        wait_ready(tag);
        check({tag, "_lat"}, LINE_W'(cyc - a), LINE_W'(1 + RD_LAT));
        e = sb.pop_front();
        check({tag, "_data"}, hrdata, e.data);
        check({tag, "_resp"}, LINE_W'(hresp), LINE_W'(e.resp));
    endtask

    initial begin
        logic [LINE_W-1:0] d1, d2, d3, d4, d5;
        exp_t e;
        int   a;

        d1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d2 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C;
        d3 = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
        d4 = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1111_EEEE;
        d5 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

        rst    = 1'b1;
        hreq   = 1'b0;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Reset and idle state
        check("rst_hready", LINE_W'(hready), LINE_W'(1));
        check("rst_hrdata", hrdata, '0);
        check("rst_hresp", LINE_W'(hresp), LINE_W'(0));
        do_read(32'h0000_0040, "rd_0x40");

        // Whole-line write, then a read of the same line
        do_write(32'h0000_0100, d1, "wr_0x100");
        do_read(32'h0000_0100, "rd_0x100");

        // Offset bits are ignored: 0x104 and 0x10C are the same line
        do_write(32'h0000_0104, d2, "wr_0x104");
        do_read(32'h0000_010C, "rd_0x10c");

        // Unmapped address: the write is dropped and hresp is raised
        do_write(32'h0001_0000, d3, "wr_unmap");
        do_read(32'h0001_0000, "rd_unmap");
        do_read(32'h0000_0000, "rd_line0");
        do_read(32'h0000_0100, "rd_mapped");

        // Back-to-back reads: hreq held high through RDONE
        do_write(32'h0000_0200, d4, "wr_0x200");
        hreq = 1'b1;
        tick();
        a = cyc;
        haddr  = 32'h0000_0100;
        hwrite = 1'b0;
        sb.push_back({1'b0, model_mem[line_of(32'h0000_0100)]});
        tick();
        haddr = 32'h0000_0200;
        sb.push_back({1'b0, model_mem[line_of(32'h0000_0200)]});
        wait_ready("b2b1");
        check("b2b1_lat", LINE_W'(cyc - a), LINE_W'(1 + RD_LAT));
        e = sb.pop_front();
        check("b2b1_data", hrdata, e.data);
        tick();
        a = cyc;
        check("b2b2_accept", LINE_W'(hready), LINE_W'(0));
        hreq = 1'b0;
        wait_ready("b2b2");
        check("b2b2_lat", LINE_W'(cyc - a), LINE_W'(1 + RD_LAT));
        e = sb.pop_front();
        check("b2b2_data", hrdata, e.data);
        check("b2b2_resp", LINE_W'(hresp), LINE_W'(e.resp));
        tick();
        check("b2b_idle", LINE_W'(hready), LINE_W'(1));

        // Reset asserted while the sequencer is in WBUSY
        hreq = 1'b1;
        tick();
        hreq   = 1'b0;
        haddr  = 32'h0000_0300;
        hwrite = 1'b1;
        tick();
        hwdata = d5;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check("rstw_hready", LINE_W'(hready), LINE_W'(1));
        check("rstw_hrdata", hrdata, '0);
        do_read(32'h0000_0300, "rstw_rd");
        do_read(32'h0000_0100, "rstw_rd_old");

        // Reset asserted while the sequencer is in RBUSY
        do_write(32'h0000_0100, d1, "wr_pre_rstr");
        do_read(32'h0000_0100, "rd_pre_rstr");
        hreq = 1'b1;
        tick();
        hreq   = 1'b0;
        haddr  = 32'h0000_0100;
        hwrite = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check("rstr_hready", LINE_W'(hready), LINE_W'(1));
        check("rstr_hrdata", hrdata, '0);
        check("rstr_hresp", LINE_W'(hresp), LINE_W'(0));
        tick();
        check("rstr_idle", LINE_W'(hready), LINE_W'(1));
        do_read(32'h0000_0100, "rstr_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
